// File: rtl/alu_seq.sv
// alu_seq: sequential ALU feeding the accumulator; single-cycle logic/arith ops,
// shift-add multiply and restoring divide, with a one-cycle load strobe.
module alu_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic [W-1:0] alu_out,
    output logic         en_da,
    output logic         busy,
    output logic         carry,
    output logic         zero,
    output logic         div_err
);
    localparam int CW = $clog2(W) + 1;
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t r_state, w_state;
    logic [W-1:0] r_a, w_a, r_b, w_b, r_quo, w_quo, r_out, w_out;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [2*W-1:0] r_prod, w_prod, w_mprod;
    logic [W:0] r_rem, w_rem, w_sum, w_dif, w_madd, w_shift, w_trial, w_nrem;
    logic [W-1:0] w_res, w_nquo;
    logic r_carry, w_carry, r_zero, w_zero, r_err, w_err, w_c, w_qbit, w_last;
    always_comb begin
        w_sum = {1'b0, a_in} + {1'b0, b_in};
        w_dif = {1'b0, a_in} - {1'b0, b_in};
        w_res = a_in;
        w_c   = 1'b0;
        case (op)
            4'd0:    {w_c, w_res} = w_sum;
            4'd1:    {w_c, w_res} = w_dif;
            4'd2:    w_res = a_in & b_in;
            4'd3:    w_res = a_in | b_in;
            4'd4:    w_res = a_in ^ b_in;
            4'd5:    w_res = ~a_in;
            4'd6:    {w_c, w_res} = {a_in, 1'b0};
            4'd7:    {w_res, w_c} = {1'b0, a_in};
            4'd10:   w_res = b_in;
            default: w_res = a_in;
        endcase
    end
    // One multiplier bit (LSB first) and one quotient bit (MSB first) per cycle
    assign w_madd  = {1'b0, r_prod[2*W-1:W]} + (r_prod[0] ? {1'b0, r_a} : '0);
    assign w_mprod = {w_madd, r_prod[W-1:1]};
    assign w_shift = {r_rem[W-1:0], r_quo[W-1]};
    assign w_trial = w_shift - {1'b0, r_b};
    assign w_qbit  = ~w_trial[W];
    assign w_nrem  = w_qbit ? w_trial : w_shift;
    assign w_nquo  = {r_quo[W-2:0], w_qbit};
    assign w_last  = r_cnt == CW'(W - 1);
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_a     = r_a;
        w_b     = r_b;
        w_prod  = r_prod;
        w_rem   = r_rem;
        w_quo   = r_quo;
        w_out   = r_out;
        w_carry = r_carry;
        w_zero  = r_zero;
        w_err   = r_err;
        case (r_state)
            IDLE: if (start) begin
                w_a   = a_in;
                w_b   = b_in;
                w_cnt = '0;
                if (op == 4'd8) begin
                    w_state = MUL;
                    w_prod  = {{W{1'b0}}, b_in};
                end else if (op == 4'd9 && b_in != '0) begin
                    w_state = DIV;
                    w_rem   = '0;
                    w_quo   = a_in;
                end else if (op == 4'd9) begin
                    w_state = DONE;
                    w_out   = '1;
                    w_carry = 1'b0;
                    w_zero  = 1'b0;
                    w_err   = 1'b1;
                end else begin
                    w_state = DONE;
                    w_out   = w_res;
                    w_carry = w_c;
                    w_zero  = w_res == '0;
                    w_err   = 1'b0;
                end
            end
            MUL: begin
                w_prod = w_mprod;
                w_cnt  = r_cnt + CW'(1);
                if (w_last) begin
                    w_state = DONE;
                    w_out   = w_mprod[W-1:0];
                    w_carry = |w_mprod[2*W-1:W];
                    w_zero  = w_mprod[W-1:0] == '0;
                    w_err   = 1'b0;
                end
            end
            DIV: begin
                w_rem = w_nrem;
                w_quo = w_nquo;
                w_cnt = r_cnt + CW'(1);
                if (w_last) begin
                    w_state = DONE;
                    w_out   = w_nquo;
                    w_carry = 1'b0;
                    w_zero  = w_nquo == '0;
                    w_err   = 1'b0;
                end
            end
            default: w_state = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_prod  <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_out   <= '0;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_a     <= w_a;
            r_b     <= w_b;
            r_prod  <= w_prod;
            r_rem   <= w_rem;
            r_quo   <= w_quo;
            r_out   <= w_out;
            r_carry <= w_carry;
            r_zero  <= w_zero;
            r_err   <= w_err;
        end
    end
    assign alu_out = r_out;
    assign en_da   = r_state == DONE;
    assign busy    = r_state != IDLE;
    assign carry   = r_carry;
    assign zero    = r_zero;
    assign div_err = r_err;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq with hand-computed results, flags and cycle counts.
module tb_alu_seq;
    logic       clk = 1'b0;
    logic       clr, start;
    logic [3:0] op;
    logic [7:0] a_in, b_in, alu_out, acc;
    logic       en_da, busy, carry, zero, div_err;
    int n_chk = 0;
    int n_pass = 0;

    alu_seq #(.W(8)) dut (
        .clk(clk), .clr(clr), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
        .alu_out(alu_out), .en_da(en_da), .busy(busy), .carry(carry), .zero(zero),
        .div_err(div_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge clr)
        if (!clr) acc <= 8'h00;
        else if (en_da) acc <= alu_out;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic issue(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a_in  = a;
        b_in  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 4'd3;
        a_in  = 8'h5A;
        b_in  = 8'hA5;
    endtask

    task automatic watch(input string name, input int nb0, input logic [7:0] eo, input logic ec,
                         input logic ez, input logic ee, input int ecyc);
        int nb, ne;
        nb = nb0;
        ne = 0;
        for (int i = 0; i < 30 && busy; i++) begin
            nb++;
            if (en_da) begin
                ne++;
                chk({name, "_out"}, alu_out, eo);
                chk({name, "_carry"}, carry, ec);
                chk({name, "_zero"}, zero, ez);
                chk({name, "_err"}, div_err, ee);
                chk({name, "_enpos"}, nb, ecyc);
            end
            @(posedge clk);
            #1;
        end
        chk({name, "_busycyc"}, nb, ecyc);
        chk({name, "_encnt"}, ne, 1);
    endtask

    task automatic run(input string name, input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eo, input logic ec, input logic ez, input logic ee, input int ecyc);
        issue(o, a, b);
        watch(name, 0, eo, ec, ez, ee, ecyc);
    endtask

    initial begin
        int ne, n_acc, n_en, n_consec;
        logic prev, w_busy;
        logic [7:0] exp_chain [6];
        exp_chain = '{8'd5, 8'd10, 8'd15, 8'd30, 8'd35, 8'd70};
        clr = 1'b1; start = 1'b0; op = 4'd0; a_in = 8'h00; b_in = 8'h00;
        #1 clr = 1'b0;
        #1;
        chk("rst0_outs", {alu_out, en_da, busy, carry, zero, div_err}, 0);
        repeat (2) @(negedge clk);
        clr = 1'b1;

        run("add_ff_01", 4'd0, 8'hFF, 8'h01, 8'h00, 1, 1, 0, 1);
        run("add_12_34", 4'd0, 8'h12, 8'h34, 8'h46, 0, 0, 0, 1);
        run("sub_03_05", 4'd1, 8'h03, 8'h05, 8'hFE, 1, 0, 0, 1);
        run("and",       4'd2, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 1);
        run("or",        4'd3, 8'h0F, 8'hA0, 8'hAF, 0, 0, 0, 1);
        run("xor",       4'd4, 8'hFF, 8'h0F, 8'hF0, 0, 0, 0, 1);
        run("not",       4'd5, 8'h55, 8'h00, 8'hAA, 0, 0, 0, 1);
        run("shl",       4'd6, 8'h81, 8'h00, 8'h02, 1, 0, 0, 1);
        run("shr",       4'd7, 8'h01, 8'h00, 8'h00, 1, 1, 0, 1);
        run("passb",     4'd10, 8'h11, 8'h77, 8'h77, 0, 0, 0, 1);
        run("passa",     4'd13, 8'h33, 8'h77, 8'h33, 0, 0, 0, 1);
        run("mul_13_11", 4'd8, 8'd13, 8'd11, 8'h8F, 0, 0, 0, 9);
        run("mul_20_10", 4'd8, 8'h20, 8'h10, 8'h00, 1, 1, 0, 9);
        run("mul_ff_ff", 4'd8, 8'hFF, 8'hFF, 8'h01, 1, 0, 0, 9);
        run("div_200_7", 4'd9, 8'd200, 8'd7, 8'd28, 0, 0, 0, 9);
        run("div_3_5",   4'd9, 8'd3, 8'd5, 8'd0, 0, 1, 0, 9);
        run("div_ff_1",  4'd9, 8'hFF, 8'h01, 8'hFF, 0, 0, 0, 9);
        run("div_5_0",   4'd9, 8'd5, 8'd0, 8'hFF, 0, 0, 1, 1);
        run("add_clr_e", 4'd0, 8'h10, 8'h20, 8'h30, 0, 0, 0, 1);

        // ADD pulsed during MUL iteration 3 must be dropped
        issue(4'd8, 8'd13, 8'd11);
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = 4'd0; a_in = 8'd1; b_in = 8'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        watch("ign_mul", 3, 8'h8F, 0, 0, 0, 9);
        ne = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (en_da) ne++;
        end
        chk("ign_no_extra_en", ne, 0);

        // Start held high: PASSB 5, then alternating SHL / ADD 5 on the accumulator
        n_acc = 0; n_en = 0; n_consec = 0; prev = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start  = n_acc < 6;
            op     = n_acc == 0 ? 4'd10 : (n_acc[0] ? 4'd6 : 4'd0);
            a_in   = acc;
            b_in   = 8'd5;
            w_busy = busy;
            @(posedge clk);
            if (start && !w_busy) n_acc++;
            #1;
            if (en_da) begin
                if (n_en < 6) chk("chain_out", alu_out, exp_chain[n_en]);
                n_en++;
            end
            if (prev && en_da) n_consec++;
            prev = en_da;
        end
        start = 1'b0;
        chk("chain_encnt", n_en, 6);
        chk("chain_consec", n_consec, 0);
        chk("chain_acc", acc, 70);

        // Asynchronous reset mid-MUL: outputs clear at once, no strobe afterwards
        run("pre_rst", 4'd1, 8'h03, 8'h05, 8'hFE, 1, 0, 0, 1);
        issue(4'd8, 8'd13, 8'd11);
        repeat (3) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("rst_out", alu_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_en", en_da, 0);
        chk("rst_flags", {carry, zero, div_err}, 0);
        @(negedge clk);
        clr = 1'b1;
        ne = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (en_da || busy) ne++;
        end
        chk("rst_no_en", ne, 0);
        run("add_1_1", 4'd0, 8'd1, 8'd1, 8'd2, 0, 0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
